tx_port_arbiter: RTL and testbench
==================================

// Module: tx_port_arbiter
// PURPOSE
//  Shares the single serial transmitter among NREQ router output requesters, round-robin.
//  Holds each winner's 55-bit packet stable on TX_Data and sequences the valid/ready
//  handshake through the transmitter's ready -> transmit -> reset -> ready cycle.
//  Acknowledges the requester once the transmitter has accepted the packet.
//  Sits between the router crossbar and the transmitter, on the serial clock domain.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  DW       55  packet width; must match transmitter TX_Data
//  TIMEOUT  8   cycles SEND waits for TX_Ready to fall before aborting (>=4)
// PORTS
//  Clk_S          in   1        serial-domain clock, rising edge
//  Rst_n          in   1        asynchronous active-low reset
//  Req_Valid      in   NREQ     per-requester packet pending
//  Req_Data       in   NREQ*DW  packets; requester i occupies bits [i*DW +: DW]
//  Req_Ack        out  NREQ     one-cycle pulse: packet i accepted by transmitter
//  Grant          out  NREQ     one-hot current owner; all zero when idle
//  TX_Data        out  DW       packet to transmitter, registered
//  TX_Data_Valid  out  1        start request to transmitter, registered
//  TX_Ready       in   1        transmitter ready (high only in its RDY state)
//  Busy           out  1        high whenever state != ARB
//  Timeout_Err    out  1        one-cycle pulse on SEND timeout
// BEHAVIOUR
//  Reset: state=ARB, Req_Ack=0, Grant=0, TX_Data=0, TX_Data_Valid=0, Busy=0,
//   Timeout_Err=0, wait counter=0, rr pointer last=NREQ-1 (requester 0 highest first).
//  All outputs are registered. Reset asserted mid-operation aborts immediately; no ack is issued.
//  ARB: if |Req_Valid && TX_Ready, choose the first set Req_Valid searching from last+1 upward,
//   wrapping modulo NREQ. At that edge: TX_Data<=Req_Data[win], Grant<=onehot(win),
//   TX_Data_Valid<=1, count<=0, go SEND. Otherwise stay in ARB with outputs unchanged.
//   No request is granted while TX_Ready=0.
//  SEND: TX_Data_Valid held 1 and TX_Data held constant; count increments each cycle.
//   TX_Ready==0 sampled: Req_Ack[win]<=1 for one cycle, TX_Data_Valid<=0, last<=win, go DRAIN.
//   Else if count==TIMEOUT-1: TX_Data_Valid<=0, Grant<=0, Timeout_Err<=1 for one cycle;
//    last is unchanged, so the same requester is retried first; go ARB.
//   The TX_Ready fall takes priority over timeout when both occur in the same cycle.
//  DRAIN: TX_Data_Valid=0, which lets the transmitter leave its reset state. TX_Data held.
//   On TX_Ready==1 sampled: Grant<=0, go ARB. A new grant is possible one cycle later at the earliest.
//   There is no timeout in DRAIN; the transmitter bounds its own frame length.
//  Requesters hold Req_Valid and Req_Data until Req_Ack. A Req_Valid drop after grant is ignored;
//   the latched packet is still sent and acked.
//  Req_Valid changes on non-granted lines never disturb an in-flight transfer.
//  Req_Ack never asserts for more than one bit or for more than one cycle per transfer.
//  Minimum spacing between successive TX_Data_Valid rises is 3 cycles (SEND, DRAIN, ARB).
// TESTING
//  1 Reset with Req_Valid=4'b1111, TX_Ready=1 -> first Grant=0001, TX_Data=Req_Data[0];
//    following grants 0010, 0100, 1000, 0001, each after its ack and TX_Ready return.
//  2 Only requester 2 valid, data 55'h12345; transmitter model drops Ready 2 cycles after valid ->
//    TX_Data=55'h12345 stable from grant until DRAIN exits; Req_Ack=0100 pulses exactly 1 cycle.
//  3 TX_Ready held 1 for the whole of SEND (stuck transmitter) -> TX_Data_Valid high 8 cycles,
//    then Timeout_Err pulses, Grant=0, and the next grant goes to the same requester.
//  4 Req_Valid=0001 raised while TX_Ready=0 -> no grant until Ready=1, then Grant=0001 next edge.
//  5 Rst_n asserted while in SEND -> all outputs 0 asynchronously; no Req_Ack; after release,
//    arbitration restarts from requester 0.
//  6 Requester 1 drops Req_Valid one cycle after grant -> its packet is still sent, Req_Ack=0010.

Source files
------------

// File: rtl/tx_port_arbiter_if.sv
// tx_port_arbiter_if: requester, transmitter and status signals shared by the arbiter and its environment
interface tx_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 55
);
  logic [NREQ-1:0]    Req_Valid;
  logic [NREQ*DW-1:0] Req_Data;
  logic [NREQ-1:0]    Req_Ack;
  logic [NREQ-1:0]    Grant;
  logic [DW-1:0]      TX_Data;
  logic               TX_Data_Valid;
  logic               TX_Ready;
  logic               Busy;
  logic               Timeout_Err;
  modport master (
    output Req_Valid, Req_Data, TX_Ready,
    input  Req_Ack, Grant, TX_Data, TX_Data_Valid, Busy, Timeout_Err
  );
  modport slave (
    input  Req_Valid, Req_Data, TX_Ready,
    output Req_Ack, Grant, TX_Data, TX_Data_Valid, Busy, Timeout_Err
  );
endinterface

// File: rtl/tx_port_arbiter.sv
// tx_port_arbiter: round-robin sharing of one serial transmitter among NREQ requesters
module tx_port_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 55,
  parameter int TIMEOUT = 8
) (
  input logic              Clk_S,
  input logic              Rst_n,
  tx_port_arbiter_if.slave bus
);
  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {ARB, SEND, DRAIN} state_t;
  state_t          state_q, state_d;
  logic [LW-1:0]   last_q, last_d, win_q, win_d, pick, cand;
  logic [CW-1:0]   count_q, count_d;
  logic [NREQ-1:0] grant_q, grant_d, ack_q, ack_d;
  logic [DW-1:0]   data_q, data_d;
  logic            valid_q, valid_d, busy_q, busy_d, terr_q, terr_d;
  assign bus.Req_Ack       = ack_q;
  assign bus.Grant         = grant_q;
  assign bus.TX_Data       = data_q;
  assign bus.TX_Data_Valid = valid_q;
  assign bus.Busy          = busy_q;
  assign bus.Timeout_Err   = terr_q;
  // first pending requester after the last winner, wrapping; scanning downward lets the nearest one win
  always_comb begin
    pick = '0;
    cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = LW'((int'(last_q) + k) % NREQ);
      if (bus.Req_Valid[cand]) pick = cand;
    end
  end
  // ARB -> SEND -> DRAIN sequencing against the transmitter's ready/transmit/reset cycle
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    count_d = count_q;
    grant_d = grant_q;
    data_d  = data_q;
    valid_d = valid_q;
    ack_d   = '0;
    terr_d  = 1'b0;
    case (state_q)
      ARB: if (|bus.Req_Valid && bus.TX_Ready) begin
        data_d  = bus.Req_Data[int'(pick)*DW +: DW];
        grant_d = NREQ'(1) << pick;
        win_d   = pick;
        valid_d = 1'b1;
        count_d = '0;
        state_d = SEND;
      end
      SEND: if (!bus.TX_Ready) begin
        ack_d   = grant_q;
        valid_d = 1'b0;
        last_d  = win_q;
        state_d = DRAIN;
      end else if (count_q == CW'(TIMEOUT - 1)) begin
        valid_d = 1'b0;
        grant_d = '0;
        terr_d  = 1'b1;
        state_d = ARB;
      end else begin
        count_d = count_q + 1'b1;
      end
      DRAIN: if (bus.TX_Ready) begin
        grant_d = '0;
        state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    busy_d = state_d != ARB;
  end
  // state and all outputs registered; reset aborts any transfer without acking
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ARB;
      last_q  <= LW'(NREQ - 1);
      win_q   <= '0;
      count_q <= '0;
      grant_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      count_q <= count_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
    end
  end
endmodule

// File: tb/tb_tx_port_arbiter.sv
// tb_tx_port_arbiter: directed scenario tests for tx_port_arbiter
module tb_tx_port_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 55;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int chk = 0;
  int pass = 0;
  logic [DW-1:0] dat [NREQ];
  tx_port_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();
  tx_port_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(8)) dut (.Clk_S(clk), .Rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load_data(input logic [DW-1:0] d2);
    for (int i = 0; i < NREQ; i++) begin
      dat[i] = (i == 2) ? d2 : DW'(64'h0A0000000000 + 64'(i) * 64'h111);
      bus.Req_Data[i*DW +: DW] = dat[i];
    end
  endtask
  task automatic apply_reset();
    rst_n = 1'b0;
    bus.Req_Valid = '0;
    bus.TX_Ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.Req_Valid = '0;
    bus.TX_Ready = 1'b1;
    load_data(55'h12345);
    #3;
    chk++; if ({bus.Grant, bus.Req_Ack, bus.TX_Data, bus.TX_Data_Valid, bus.Busy, bus.Timeout_Err} !== '0) $display("FAIL reset_outs got g=%b a=%b d=%h v=%b", bus.Grant, bus.Req_Ack, bus.TX_Data, bus.TX_Data_Valid); else pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    step();
    chk++; if ({bus.Grant, bus.Busy} !== '0) $display("FAIL reset_idle got g=%b busy=%b want 0", bus.Grant, bus.Busy); else pass++;
  endtask
  task automatic test_round_robin();
    logic [NREQ-1:0] eg;
    apply_reset();
    bus.Req_Valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      eg = NREQ'(1) << (i % NREQ);
      step();
      chk++; if (bus.Grant !== eg || bus.TX_Data !== dat[i%NREQ] || bus.TX_Data_Valid !== 1'b1) $display("FAIL rr_grant%0d got g=%b d=%h v=%b want g=%b d=%h", i, bus.Grant, bus.TX_Data, bus.TX_Data_Valid, eg, dat[i%NREQ]); else pass++;
      bus.TX_Ready = 1'b0;
      step();
      chk++; if (bus.Req_Ack !== eg || bus.TX_Data_Valid !== 1'b0) $display("FAIL rr_ack%0d got a=%b v=%b want a=%b", i, bus.Req_Ack, bus.TX_Data_Valid, eg); else pass++;
      bus.TX_Ready = 1'b1;
      step();
      chk++; if (bus.Grant !== '0 || bus.Req_Ack !== '0 || bus.Busy !== 1'b0) $display("FAIL rr_drain%0d got g=%b a=%b busy=%b want 0", i, bus.Grant, bus.Req_Ack, bus.Busy); else pass++;
    end
  endtask
  task automatic test_single_packet();
    int acks = 0;
    apply_reset();
    bus.Req_Valid = 4'b0100;
    step();
    chk++; if (bus.Grant !== 4'b0100 || bus.TX_Data !== 55'h12345) $display("FAIL sp_grant got g=%b d=%h want 0100 12345", bus.Grant, bus.TX_Data); else pass++;
    step();
    acks += (bus.Req_Ack != 0) ? 1 : 0;
    chk++; if (bus.TX_Data !== 55'h12345 || bus.TX_Data_Valid !== 1'b1 || bus.Busy !== 1'b1) $display("FAIL sp_send got d=%h v=%b busy=%b", bus.TX_Data, bus.TX_Data_Valid, bus.Busy); else pass++;
    bus.TX_Ready = 1'b0;
    step();
    acks += (bus.Req_Ack != 0) ? 1 : 0;
    chk++; if (bus.Req_Ack !== 4'b0100 || bus.TX_Data !== 55'h12345 || bus.TX_Data_Valid !== 1'b0) $display("FAIL sp_ack got a=%b d=%h v=%b want 0100", bus.Req_Ack, bus.TX_Data, bus.TX_Data_Valid); else pass++;
    bus.Req_Valid = '0;
    step();
    acks += (bus.Req_Ack != 0) ? 1 : 0;
    chk++; if (bus.Grant !== 4'b0100 || bus.TX_Data !== 55'h12345 || bus.Busy !== 1'b1) $display("FAIL sp_drain got g=%b d=%h busy=%b", bus.Grant, bus.TX_Data, bus.Busy); else pass++;
    bus.TX_Ready = 1'b1;
    step();
    acks += (bus.Req_Ack != 0) ? 1 : 0;
    chk++; if (bus.Grant !== '0 || bus.TX_Data !== 55'h12345 || bus.Busy !== 1'b0) $display("FAIL sp_exit got g=%b d=%h busy=%b", bus.Grant, bus.TX_Data, bus.Busy); else pass++;
    chk++; if (acks !== 1) $display("FAIL sp_ack_cycles got %0d want 1", acks); else pass++;
  endtask
  task automatic test_timeout();
    int vcnt = 1;
    apply_reset();
    bus.Req_Valid = 4'b0001;
    step();
    bus.TX_Ready = 1'b0;
    step();
    bus.TX_Ready = 1'b1;
    bus.Req_Valid = 4'b0110;
    step();
    step();
    chk++; if (bus.Grant !== 4'b0010) $display("FAIL to_grant got %b want 0010", bus.Grant); else pass++;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.TX_Data_Valid) vcnt++;
      else break;
    end
    chk++; if (vcnt !== 8) $display("FAIL to_valid_cycles got %0d want 8", vcnt); else pass++;
    chk++; if (bus.Timeout_Err !== 1'b1 || bus.Grant !== '0 || bus.Req_Ack !== '0) $display("FAIL to_abort got err=%b g=%b a=%b", bus.Timeout_Err, bus.Grant, bus.Req_Ack); else pass++;
    step();
    chk++; if (bus.Timeout_Err !== 1'b0 || bus.Grant !== 4'b0010) $display("FAIL to_retry got err=%b g=%b want 0 0010", bus.Timeout_Err, bus.Grant); else pass++;
  endtask
  task automatic test_ready_low();
    apply_reset();
    bus.TX_Ready = 1'b0;
    bus.Req_Valid = 4'b0001;
    repeat (3) step();
    chk++; if (bus.Grant !== '0 || bus.TX_Data_Valid !== 1'b0 || bus.Busy !== 1'b0) $display("FAIL rl_hold got g=%b v=%b busy=%b want 0", bus.Grant, bus.TX_Data_Valid, bus.Busy); else pass++;
    bus.TX_Ready = 1'b1;
    step();
    chk++; if (bus.Grant !== 4'b0001 || bus.TX_Data_Valid !== 1'b1) $display("FAIL rl_grant got g=%b v=%b want 0001 1", bus.Grant, bus.TX_Data_Valid); else pass++;
  endtask
  task automatic test_async_reset();
    int acks = 0;
    apply_reset();
    bus.Req_Valid = 4'b0001;
    step();
    step();
    chk++; if (bus.TX_Data_Valid !== 1'b1) $display("FAIL ar_send got v=%b want 1", bus.TX_Data_Valid); else pass++;
    #2 rst_n = 1'b0;
    bus.TX_Ready = 1'b0;
    #1;
    chk++; if ({bus.Grant, bus.Req_Ack, bus.TX_Data, bus.TX_Data_Valid, bus.Busy, bus.Timeout_Err} !== '0) $display("FAIL ar_outs got g=%b a=%b d=%h v=%b", bus.Grant, bus.Req_Ack, bus.TX_Data, bus.TX_Data_Valid); else pass++;
    step();
    acks += (bus.Req_Ack != 0) ? 1 : 0;
    rst_n = 1'b1;
    bus.TX_Ready = 1'b1;
    bus.Req_Valid = 4'b1111;
    step();
    acks += (bus.Req_Ack != 0) ? 1 : 0;
    chk++; if (bus.Grant !== 4'b0001 || acks !== 0) $display("FAIL ar_restart got g=%b acks=%0d want 0001 0", bus.Grant, acks); else pass++;
  endtask
  task automatic test_valid_drop();
    apply_reset();
    bus.Req_Valid = 4'b0010;
    step();
    chk++; if (bus.Grant !== 4'b0010 || bus.TX_Data !== dat[1]) $display("FAIL vd_grant got g=%b d=%h want 0010 %h", bus.Grant, bus.TX_Data, dat[1]); else pass++;
    bus.Req_Valid = '0;
    step();
    bus.TX_Ready = 1'b0;
    step();
    chk++; if (bus.Req_Ack !== 4'b0010 || bus.TX_Data !== dat[1]) $display("FAIL vd_ack got a=%b d=%h want 0010", bus.Req_Ack, bus.TX_Data); else pass++;
    bus.TX_Ready = 1'b1;
    step();
    step();
    chk++; if (bus.Grant !== '0 || bus.Busy !== 1'b0) $display("FAIL vd_idle got g=%b busy=%b want 0", bus.Grant, bus.Busy); else pass++;
  endtask
  initial begin
    bus.Req_Valid = '0;
    bus.Req_Data = '0;
    bus.TX_Ready = 1'b1;
    test_reset();
    test_round_robin();
    test_single_packet();
    test_timeout();
    test_ready_low();
    test_async_reset();
    test_valid_drop();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
